// File: rtl/object_position_pkg.sv
// object_position_pkg: shared screen geometry, FSM encoding and step sign constants
package object_position_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int INIT_X = 80;
  localparam int INIT_Y = 60;
  localparam logic SIGN_POS = 1'b0;
  localparam logic SIGN_NEG = 1'b1;
  typedef enum logic {RUN = 1'b0, SPAWN = 1'b1} state_t;
endpackage

// File: rtl/object_position_if.sv
// object_position_if: step, spawn and snapshot signals between the decoder/renderer and one object
interface object_position_if #(parameter int X_W = 8, parameter int Y_W = 7);
  logic move_clk;
  logic delta_x;
  logic delta_y;
  logic sign_x;
  logic sign_y;
  logic spawn_valid;
  logic spawn_ready;
  logic [X_W-1:0] spawn_x;
  logic [Y_W-1:0] spawn_y;
  logic [X_W-1:0] pos_x;
  logic [Y_W-1:0] pos_y;
  logic wrapped_x;
  logic wrapped_y;
  logic frame_tick;
  logic snap_valid;
  logic snap_ready;
  logic [X_W-1:0] snap_x;
  logic [Y_W-1:0] snap_y;
  logic [7:0] snap_steps;
  logic snap_overrun;
  modport master (
    output move_clk, delta_x, delta_y, sign_x, sign_y, spawn_valid, spawn_x, spawn_y, frame_tick, snap_ready,
    input spawn_ready, pos_x, pos_y, wrapped_x, wrapped_y, snap_valid, snap_x, snap_y, snap_steps, snap_overrun
  );
  modport slave (
    input move_clk, delta_x, delta_y, sign_x, sign_y, spawn_valid, spawn_x, spawn_y, frame_tick, snap_ready,
    output spawn_ready, pos_x, pos_y, wrapped_x, wrapped_y, snap_valid, snap_x, snap_y, snap_steps, snap_overrun
  );
endinterface

// File: rtl/object_position_wrap_axis_counter.sv
// wrap_axis_counter: one coordinate axis, 0..MAX with wrap-around stepping and a clamped load
module wrap_axis_counter
  import object_position_pkg::*;
#(
  parameter int MAX = 159,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         step,
  input  logic         sign,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] rst_val,
  output logic [W-1:0] value,
  output logic         wrap
);
  logic [W-1:0] value_nxt;
  logic wrap_nxt;
  logic at_top, at_bot;
  assign at_top = value == W'(MAX);
  assign at_bot = value == '0;
  always_comb begin
    value_nxt = value;
    wrap_nxt = 1'b0;
    if (load) value_nxt = load_val > W'(MAX) ? W'(MAX) : load_val;
    else if (step) begin
      value_nxt = sign == SIGN_POS ? (at_top ? '0 : value + W'(1)) : (at_bot ? W'(MAX) : value - W'(1));
      wrap_nxt = sign == SIGN_POS ? at_top : at_bot;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      value <= rst_val;
      wrap <= 1'b0;
    end else begin
      value <= value_nxt;
      wrap <= wrap_nxt;
    end
  end
endmodule

// File: rtl/object_position.sv
// object_position: wrap-around object coordinate with spawn handshake and per-frame snapshot
module object_position #(
  parameter int SCREEN_W = object_position_pkg::SCREEN_W,
  parameter int SCREEN_H = object_position_pkg::SCREEN_H,
  parameter int X_W = object_position_pkg::X_W,
  parameter int Y_W = object_position_pkg::Y_W,
  parameter int INIT_X = object_position_pkg::INIT_X,
  parameter int INIT_Y = object_position_pkg::INIT_Y
) (
  input logic clk,
  input logic reset_n,
  object_position_if.slave bus
);
  import object_position_pkg::*;
  state_t state, state_nxt;
  logic accept, step_x, step_y;
  logic [7:0] steps, steps_nxt;
  logic [8:0] steps_sum;
  always_ff @(posedge clk) begin
    if (!reset_n) state <= RUN;
    else state <= state_nxt;
  end
  // Steps are dropped both in the accept cycle and in the SPAWN cycle after it
  always_comb begin
    state_nxt = RUN;
    accept = 1'b0;
    step_x = 1'b0;
    step_y = 1'b0;
    accept = state == RUN && bus.spawn_valid;
    state_nxt = accept ? SPAWN : RUN;
    step_x = state == RUN && !bus.spawn_valid && bus.move_clk && bus.delta_x;
    step_y = state == RUN && !bus.spawn_valid && bus.move_clk && bus.delta_y;
  end
  assign bus.spawn_ready = state == RUN;
  wrap_axis_counter #(.MAX(SCREEN_W - 1), .W(X_W)) u_x (
    .clk(clk), .reset_n(reset_n), .step(step_x), .sign(bus.sign_x), .load(accept),
    .load_val(bus.spawn_x), .rst_val(X_W'(INIT_X)), .value(bus.pos_x), .wrap(bus.wrapped_x)
  );
  wrap_axis_counter #(.MAX(SCREEN_H - 1), .W(Y_W)) u_y (
    .clk(clk), .reset_n(reset_n), .step(step_y), .sign(bus.sign_y), .load(accept),
    .load_val(bus.spawn_y), .rst_val(Y_W'(INIT_Y)), .value(bus.pos_y), .wrap(bus.wrapped_y)
  );
  assign steps_sum = {1'b0, steps} + 9'(step_x) + 9'(step_y);
  assign steps_nxt = steps_sum[8] ? 8'hff : steps_sum[7:0];
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      steps <= '0;
      bus.snap_valid <= 1'b0;
      bus.snap_x <= '0;
      bus.snap_y <= '0;
      bus.snap_steps <= '0;
      bus.snap_overrun <= 1'b0;
    end else begin
      steps <= bus.frame_tick ? '0 : steps_nxt;
      bus.snap_overrun <= bus.frame_tick && bus.snap_valid && !bus.snap_ready;
      if (bus.frame_tick) begin
        bus.snap_valid <= 1'b1;
        bus.snap_x <= bus.pos_x;
        bus.snap_y <= bus.pos_y;
        bus.snap_steps <= steps_nxt;
      end else if (bus.snap_ready) bus.snap_valid <= 1'b0;
    end
  end
endmodule
